// File: rtl/fu_issue_queue_pkg.sv
// Shared types and helpers for the RS->FU issue queue: micro-op layout and ROB age compare.
package fu_issue_queue_pkg;

    localparam int unsigned FU_NUM  = 4;
    localparam int unsigned ROB_W   = 6;
    localparam int unsigned PHYS_W  = 6;
    localparam int unsigned EPOCH_W = 2;

    typedef struct packed {
        logic [ROB_W-1:0]   rob_idx;
        logic [PHYS_W-1:0]  prs1;
        logic [PHYS_W-1:0]  prs2;
        logic [PHYS_W-1:0]  prd;
        logic [7:0]         opcode;
        logic [EPOCH_W-1:0] epoch;
    } rs_uop_t;

    // Ages are distances from the ROB head, so the ROB_W-bit subtract handles index wrap.
    function automatic logic rob_is_younger(input logic [ROB_W-1:0] idx,
                                            input logic [ROB_W-1:0] ref_idx,
                                            input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] age_idx;
        logic [ROB_W-1:0] age_ref;
        age_idx = idx - head;
        age_ref = ref_idx - head;
        return age_idx > age_ref;
    endfunction

endpackage

// File: rtl/fu_issue_fifo.sv
// One issue channel: circular buffer with live bits for selective kill, optional bypass when empty.
module fu_issue_fifo
    import fu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  rs_uop_t                      i_in_uop,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output rs_uop_t                      o_out_uop,
    input  logic                         i_flush_valid,
    input  logic                         i_recover_valid,
    input  logic [ROB_W-1:0]             i_recover_rob_idx,
    input  logic [ROB_W-1:0]             i_rob_head_idx,
    output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    rs_uop_t          r_uop [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_head_live;
    logic             w_drop_in;
    logic             w_bypass;
    logic             w_bypass_take;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_kill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        w_empty     = (r_count == '0);
        w_head_live = r_live[r_rd_ptr];
        w_drop_in   = i_recover_valid
                      && rob_is_younger(i_in_uop.rob_idx, i_recover_rob_idx, i_rob_head_idx);
        w_bypass    = BYPASS && w_empty && i_in_valid && !w_drop_in;
        o_out_valid = !i_rst && !i_flush_valid && ((!w_empty && w_head_live) || w_bypass);
        o_out_uop   = w_empty ? i_in_uop : r_uop[r_rd_ptr];
        o_in_ready  = !i_rst && ((r_count < CNT_FULL) || (o_out_valid && i_out_ready));
        // A bypassed uop taken by the FU in the same cycle never occupies a slot.
        w_bypass_take = w_bypass && o_out_valid && i_out_ready;
        w_push      = i_in_valid && o_in_ready && !w_drop_in && !i_flush_valid && !w_bypass_take;
        w_pop       = !w_empty && (i_out_ready || !w_head_live);
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i] = i_recover_valid
                        && rob_is_younger(r_uop[i].rob_idx, i_recover_rob_idx, i_rob_head_idx);
        end
        o_occupancy = r_count;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_live   <= '0;
        end else if (i_flush_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_live   <= '0;
        end else begin
            // Killed slots stay allocated as bubbles; the push below may reuse a freed slot.
            r_live <= r_live & ~w_kill;
            if (w_push) begin
                r_live[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_uop[r_wr_ptr] <= i_in_uop;
        end
    end

endmodule

// File: rtl/fu_issue_queue.sv
// RS->FU issue decoupling: NUM_CH independent channels, PRF read addresses driven from each head.
module fu_issue_queue
    import fu_issue_queue_pkg::*;
#(
    parameter int unsigned NUM_CH = FU_NUM,
    parameter int unsigned DEPTH  = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic    [NUM_CH-1:0]                      i_in_valid,
    output logic    [NUM_CH-1:0]                      o_in_ready,
    input  rs_uop_t [NUM_CH-1:0]                      i_in_uop,
    output logic    [NUM_CH-1:0]                      o_out_valid,
    input  logic    [NUM_CH-1:0]                      i_out_ready,
    output rs_uop_t [NUM_CH-1:0]                      o_out_uop,
    output logic    [NUM_CH-1:0][PHYS_W-1:0]          o_raddr1,
    output logic    [NUM_CH-1:0][PHYS_W-1:0]          o_raddr2,
    input  logic                                      i_flush_valid,
    input  logic                                      i_recover_valid,
    input  logic    [ROB_W-1:0]                       i_recover_rob_idx,
    input  logic    [ROB_W-1:0]                       i_rob_head_idx,
    output logic    [NUM_CH-1:0][$clog2(DEPTH+1)-1:0] o_occupancy,
    output logic                                      o_busy
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fu_issue_fifo #(
            .DEPTH  (DEPTH),
            .BYPASS (BYPASS)
        ) u_fifo (
            .i_clk             (i_clk),
            .i_rst             (i_rst),
            .i_in_valid        (i_in_valid[g]),
            .o_in_ready        (o_in_ready[g]),
            .i_in_uop          (i_in_uop[g]),
            .o_out_valid       (o_out_valid[g]),
            .i_out_ready       (i_out_ready[g]),
            .o_out_uop         (o_out_uop[g]),
            .i_flush_valid     (i_flush_valid),
            .i_recover_valid   (i_recover_valid),
            .i_recover_rob_idx (i_recover_rob_idx),
            .i_rob_head_idx    (i_rob_head_idx),
            .o_occupancy       (o_occupancy[g])
        );
    end

    always_comb begin
        o_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_raddr1[c] = o_out_valid[c] ? o_out_uop[c].prs1 : '0;
            o_raddr2[c] = o_out_valid[c] ? o_out_uop[c].prs2 : '0;
            o_busy      = o_busy || (o_occupancy[c] != '0);
        end
    end

endmodule

// File: tb/tb_fu_issue_queue.sv
// Bench for fu_issue_queue: registered DEPTH=2 instance (a) and bypass DEPTH=4 instance (b).
module tb_fu_issue_queue;
    import fu_issue_queue_pkg::*;

    logic clk;
    logic rst;

    logic    [1:0]             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    rs_uop_t [1:0]             a_in_uop, a_out_uop;
    logic    [1:0][PHYS_W-1:0] a_raddr1, a_raddr2;
    logic                      a_flush, a_recover;
    logic    [ROB_W-1:0]       a_rec_idx, a_head;
    logic    [1:0][1:0]        a_occ;
    logic                      a_busy;

    logic    [1:0]             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    rs_uop_t [1:0]             b_in_uop, b_out_uop;
    logic    [1:0][PHYS_W-1:0] b_raddr1, b_raddr2;
    logic                      b_flush, b_recover;
    logic    [ROB_W-1:0]       b_rec_idx, b_head;
    logic    [1:0][2:0]        b_occ;
    logic                      b_busy;

    fu_issue_queue #(.NUM_CH(2), .DEPTH(2), .BYPASS(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_uop(a_in_uop),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_uop(a_out_uop),
        .o_raddr1(a_raddr1), .o_raddr2(a_raddr2),
        .i_flush_valid(a_flush), .i_recover_valid(a_recover),
        .i_recover_rob_idx(a_rec_idx), .i_rob_head_idx(a_head),
        .o_occupancy(a_occ), .o_busy(a_busy)
    );

    fu_issue_queue #(.NUM_CH(2), .DEPTH(4), .BYPASS(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_uop(b_in_uop),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_uop(b_out_uop),
        .o_raddr1(b_raddr1), .o_raddr2(b_raddr2),
        .i_flush_valid(b_flush), .i_recover_valid(b_recover),
        .i_recover_rob_idx(b_rec_idx), .i_rob_head_idx(b_head),
        .o_occupancy(b_occ), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int seq      = 0;

    typedef struct {
        logic       in_v;
        logic [5:0] prs1;
        logic       out_r;
        logic       flush;
        logic       e_ov;
        logic       e_ir;
        logic [1:0] e_occ;
        logic [5:0] e_ra1;
    } vec_t;
    vec_t vecs [14];

    rs_uop_t model [$];
    rs_uop_t keep  [$];
    int      got   [$];
    rs_uop_t prev_uop;
    logic    prev_hold;
    rs_uop_t exp_uop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rs_uop_t mk(input logic [5:0] rob, input logic [5:0] p1,
                                   input logic [5:0] p2, input logic [7:0] op);
        rs_uop_t u;
        u = '0;
        u.rob_idx = rob;
        u.prs1    = p1;
        u.prs2    = p2;
        u.prd     = p1 ^ p2;
        u.opcode  = op;
        return u;
    endfunction

    // Reference age compare done with integer modulo arithmetic.
    function automatic logic tb_younger(input int idx, input int r, input int h);
        return ((idx - h + 64) % 64) > ((r - h + 64) % 64);
    endfunction

    task automatic sb_step();
        if (b_in_valid[0] && b_in_ready[0] && !b_flush
            && !(b_recover && tb_younger(int'(b_in_uop[0].rob_idx), int'(b_rec_idx),
                                         int'(b_head))))
            model.push_back(b_in_uop[0]);
        if (b_out_valid[0] && b_out_ready[0]) begin
            if (model.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rand_extra: got uop 0x%0h expected none", b_out_uop[0]);
            end else begin
                chk("rand_order", 64'(b_out_uop[0]), 64'(model[0]));
                void'(model.pop_front());
            end
        end
        if (b_flush) begin
            model.delete();
        end else if (b_recover) begin
            keep.delete();
            foreach (model[k])
                if (!tb_younger(int'(model[k].rob_idx), int'(b_rec_idx), int'(b_head)))
                    keep.push_back(model[k]);
            model = keep;
        end
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = '0; a_out_ready = '0; a_in_uop = '0; a_flush = 1'b0;
        a_recover = 1'b0; a_rec_idx = '0; a_head = '0;
        b_in_valid = '0; b_out_ready = '0; b_in_uop = '0; b_flush = 1'b0;
        b_recover = 1'b0; b_rec_idx = '0; b_head = '0;
        prev_hold = 1'b0;
        prev_uop  = '0;

        vecs[0]  = '{1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd0};
        vecs[1]  = '{1'b1, 6'd11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 6'd10};
        vecs[2]  = '{1'b1, 6'd12, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 6'd10};
        vecs[3]  = '{1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 6'd10};
        vecs[4]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 6'd11};
        vecs[5]  = '{1'b1, 6'd13, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 6'd12};
        vecs[6]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 6'd13};
        vecs[7]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 6'd13};
        vecs[8]  = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd0};
        vecs[9]  = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 6'd0};
        vecs[10] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd0};
        vecs[11] = '{1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd0};
        vecs[12] = '{1'b1, 6'd11, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 6'd0};
        vecs[13] = '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd0};

        // Reset values while rst is held.
        #1;
        chk("rst_a_ov", 64'(a_out_valid), 64'(0));
        chk("rst_a_ir", 64'(a_in_ready), 64'(0));
        chk("rst_b_busy", 64'(b_busy), 64'(0));
        chk("rst_b_occ", 64'(b_occ), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven sequence on registered channel 0.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            a_in_valid[0]  = vecs[i].in_v;
            a_in_uop[0]    = mk(6'd0, vecs[i].prs1, vecs[i].prs1 + 6'd1, 8'(i));
            a_out_ready[0] = vecs[i].out_r;
            a_flush        = vecs[i].flush;
            #4;
            chk($sformatf("v%0d_ov", i), 64'(a_out_valid[0]), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_ir", i), 64'(a_in_ready[0]), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d_occ", i), 64'(a_occ[0]), 64'(vecs[i].e_occ));
            chk($sformatf("v%0d_ra1", i), 64'(a_raddr1[0]), 64'(vecs[i].e_ra1));
        end
        @(negedge clk);
        a_in_valid = '0; a_out_ready = '0; a_flush = 1'b0;

        // Asynchronous reset with two entries held in ch0.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_in_valid[0] = 1'b1;
            a_in_uop[0]   = mk(6'd0, 6'(20 + i), 6'd1, 8'd0);
        end
        @(negedge clk);
        chk("pre_rst_occ", 64'(a_occ[0]), 64'(2));
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", 64'(a_out_valid[0]), 64'(0));
        chk("mid_rst_occ", 64'(a_occ[0]), 64'(0));
        chk("mid_rst_busy", 64'(a_busy), 64'(0));
        chk("mid_rst_ra1", 64'(a_raddr1[0]), 64'(0));
        chk("mid_rst_ir", 64'(a_in_ready[0]), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        a_in_valid = '0;

        // Flush with every channel full and new uops arriving.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_in_valid = 2'b11;
            a_in_uop   = {mk(6'd0, 6'(30 + i), 6'd2, 8'd1), mk(6'd0, 6'(40 + i), 6'd3, 8'd2)};
        end
        @(negedge clk);
        a_flush = 1'b1;
        #4;
        chk("flush_cyc_ov", 64'(a_out_valid), 64'(0));
        chk("flush_cyc_busy", 64'(a_busy), 64'(1));
        @(negedge clk);
        a_flush = 1'b0;
        a_in_valid = '0;
        #4;
        chk("flush_occ0", 64'(a_occ[0]), 64'(0));
        chk("flush_occ1", 64'(a_occ[1]), 64'(0));
        chk("flush_busy", 64'(a_busy), 64'(0));
        chk("flush_ov", 64'(a_out_valid), 64'(0));

        // Stall hold on ch1 for ten cycles.
        exp_uop = mk(6'd3, 6'd7, 6'd9, 8'h55);
        @(negedge clk);
        a_in_valid[1] = 1'b1;
        a_in_uop[1]   = exp_uop;
        @(negedge clk);
        a_in_uop[1]   = mk(6'd4, 6'd20, 6'd21, 8'h56);
        for (int i = 0; i < 10; i++) begin
            #4;
            chk("stall_ov", 64'(a_out_valid[1]), 64'(1));
            chk("stall_uop", 64'(a_out_uop[1]), 64'(exp_uop));
            chk("stall_ra1", 64'(a_raddr1[1]), 64'(7));
            chk("stall_ra2", 64'(a_raddr2[1]), 64'(9));
            @(negedge clk);
            a_in_valid[1] = 1'b0;
        end
        a_out_ready[1] = 1'b1;
        @(negedge clk);
        #4;
        chk("stall_next_ra1", 64'(a_raddr1[1]), 64'(20));
        @(negedge clk);
        a_out_ready = '0;

        // Zero-latency bypass on empty ch1.
        @(negedge clk);
        b_in_valid[1]  = 1'b1;
        b_in_uop[1]    = mk(6'd0, 6'd5, 6'd6, 8'd9);
        b_out_ready[1] = 1'b1;
        #4;
        chk("byp_ov", 64'(b_out_valid[1]), 64'(1));
        chk("byp_ra1", 64'(b_raddr1[1]), 64'(5));
        chk("byp_occ_same", 64'(b_occ[1]), 64'(0));
        @(negedge clk);
        b_in_valid = '0;
        b_out_ready = '0;
        #4;
        chk("byp_occ_after", 64'(b_occ[1]), 64'(0));
        chk("byp_ov_after", 64'(b_out_valid[1]), 64'(0));
        chk("byp_busy", 64'(b_busy), 64'(0));

        // Recover with ROB wrap: head 60, entries 62,1,63, branch 63.
        b_head = 6'd60;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_in_valid[0] = 1'b1;
            b_in_uop[0]   = mk((i == 0) ? 6'd62 : (i == 1) ? 6'd1 : 6'd63, 6'(i + 1), 6'd0, 8'd0);
        end
        @(negedge clk);
        b_recover     = 1'b1;
        b_rec_idx     = 6'd63;
        b_in_uop[0]   = mk(6'd2, 6'd4, 6'd0, 8'd0);
        #4;
        chk("rec_ir", 64'(b_in_ready[0]), 64'(1));
        chk("rec_head", 64'(b_out_uop[0].rob_idx), 64'(62));
        chk("rec_occ", 64'(b_occ[0]), 64'(3));
        @(negedge clk);
        b_recover      = 1'b0;
        b_in_valid     = '0;
        b_out_ready[0] = 1'b1;
        #4;
        chk("rec_occ_after", 64'(b_occ[0]), 64'(3));
        got.delete();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) #4;
            if (b_out_valid[0] && b_out_ready[0]) got.push_back(int'(b_out_uop[0].rob_idx));
            @(negedge clk);
        end
        chk("rec_count", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            chk("rec_first", 64'(got[0]), 64'(62));
            chk("rec_second", 64'(got[1]), 64'(63));
        end
        chk("rec_drained", 64'(b_occ[0]), 64'(0));

        // Random push/pop/recover/flush against the scoreboard on bypass ch0.
        model.delete();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            b_in_valid[0]  = ($urandom_range(9) < 6);
            b_in_uop[0]    = mk(6'($urandom), 6'($urandom), 6'($urandom), 8'(seq));
            seq++;
            b_out_ready[0] = ($urandom_range(9) < 6);
            b_recover      = ($urandom_range(19) == 0);
            b_rec_idx      = 6'($urandom);
            b_head         = 6'($urandom);
            b_flush        = ($urandom_range(99) == 0);
            #4;
            if (prev_hold && b_out_valid[0])
                chk("rand_hold", 64'(b_out_uop[0]), 64'(prev_uop));
            sb_step();
            prev_hold = b_out_valid[0] && !b_out_ready[0];
            prev_uop  = b_out_uop[0];
        end
        @(negedge clk);
        b_in_valid = '0; b_recover = 1'b0; b_flush = 1'b0; b_out_ready[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #4;
            sb_step();
            @(negedge clk);
        end
        chk("rand_model_empty", 64'(model.size()), 64'(0));
        chk("rand_occ_end", 64'(b_occ[0]), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
